// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the 10-bit binary to 3-digit BCD converter.
package bin_to_bcd_pkg;

    localparam int BIN_W   = 10;   // width of the binary input
    localparam int DIGITS  = 3;    // BCD digits produced (hundreds, tens, units)
    localparam int SHIFTS  = 10;   // one double-dabble step per input bit
    localparam int MAX_VAL = 999;  // largest value representable in DIGITS digits

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: digits of 5 or more get +3 so
// that the following left shift carries correctly into the next digit.
module bcd_add3_digit (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Pure combinational correction, no state.
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_trio.sv
// Sequential double-dabble converter: 10-bit binary to three BCD digits with a
// fixed 11-cycle start-to-done latency (10 SHIFT cycles, then one DONE cycle).
// Optional macro BIN_TO_BCD_TRIO_SAT_EN: values above 999 saturate to 9/9/9
// with ovf=1; without it such values wrap modulo 1000 and ovf stays 0.
module bin_to_bcd_trio
    import bin_to_bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [3:0]       num0,
    output logic [3:0]       num1,
    output logic [3:0]       num2,
    output logic             ovf
);

`ifdef BIN_TO_BCD_TRIO_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam int              ACC_W    = 4 * DIGITS;
    localparam logic [3:0]      LAST_CNT = 4'(SHIFTS - 1);
    localparam logic [ACC_W-1:0] NINES   = {DIGITS{4'd9}};

    state_t             state_q;
    logic [BIN_W-1:0]   bin_q;
    logic [ACC_W-1:0]   acc_q;
    logic [3:0]         cnt_q;
    logic               big_q;
    logic               busy_q;
    logic               done_q;
    logic [ACC_W-1:0]   num_q;
    logic               ovf_q;

    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_d;
    logic [BIN_W-1:0]   bin_d;
    logic               big_d;

    // Per-digit add-3 correction ahead of every shift.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_add3
            bcd_add3_digit u_add3 (
                .digit_i (acc_q[4*gi +: 4]),
                .digit_o (acc_adj[4*gi +: 4])
            );
        end
    endgenerate

    // Shift {accumulator, binary} left by one. The bit leaving the top digit
    // is a thousands carry: the running prefix has reached 1000, so the final
    // value exceeds 999. It is sticky for the rest of the conversion.
    assign acc_d = {acc_adj[ACC_W-2:0], bin_q[BIN_W-1]};
    assign bin_d = {bin_q[BIN_W-2:0], 1'b0};
    assign big_d = big_q | acc_adj[ACC_W-1];

    // Control FSM with all outputs registered; results load on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            big_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            num_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_q   <= bin;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        big_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    bin_q <= bin_d;
                    big_q <= big_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        num_q   <= (SAT_EN && big_d) ? NINES : acc_d;
                        ovf_q   <= SAT_EN && big_d;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign num0 = num_q[3:0];
    assign num1 = num_q[7:4];
    assign num2 = num_q[11:8];
    assign ovf  = ovf_q;

endmodule

// File: doc/bin_to_bcd_trio.md
BIN_TO_BCD_TRIO -- requirements
Module: bin_to_bcd_trio

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: conversion request, sampled only in IDLE.
REQ-004 SHALL have port bin, input, 10 bits: unsigned binary value to convert.
REQ-005 SHALL have port busy, output, 1 bit: high while a conversion is in progress (SHIFT or DONE).
REQ-006 SHALL have port done, output, 1 bit: one-cycle pulse; drives the display driver's trigger.
REQ-007 SHALL have port num0, output, 4 bits: BCD units digit, feeds driver num0.
REQ-008 SHALL have port num1, output, 4 bits: BCD tens digit, feeds driver num1.
REQ-009 SHALL have port num2, output, 4 bits: BCD hundreds digit, feeds driver num2.
REQ-010 SHALL have port ovf, output, 1 bit: captured bin exceeded 999 (see Configuration).

Function
REQ-011 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1 at edge t, SHALL capture bin into a shift register, clear the BCD accumulator and a 4-bit counter, and enter SHIFT.
REQ-013 In SHIFT, each cycle SHALL add 3 to every accumulator digit >=5, then shift {accumulator, binary} left by one bit; after 10 shifts SHALL enter DONE.
REQ-014 SHALL place SHIFT at edges t+1..t+10, DONE at t+11 and IDLE at t+12, giving a fixed latency of 11 cycles from start to done.
REQ-015 In DONE, SHALL assert done=1 for exactly one cycle and update num0..num2 and ovf in that same cycle.
REQ-016 SHALL hold num0..num2 and ovf stable between done pulses; outputs are registered and never show intermediate values.
REQ-017 SHALL ignore start while busy=1; SHALL leave bin as a don't-care outside the capture edge.
REQ-018 With start held high continuously, SHALL start a new conversion every 12 cycles.
REQ-019 SHALL keep every output digit within 0..9.

Reset
REQ-020 On rst=1, SHALL immediately force the FSM to IDLE with busy=0, done=0, num0=num1=num2=0 and ovf=0.
REQ-021 A reset asserted mid-conversion SHALL abort the conversion without emitting a done pulse; the first start after release begins a fresh conversion.

Configuration
REQ-022 Macro BIN_TO_BCD_TRIO_SAT_EN, when defined: SHALL drive num2/num1/num0 = 9/9/9 and ovf=1 for any captured bin >999.
REQ-023 Macro BIN_TO_BCD_TRIO_SAT_EN, when undefined: SHALL keep ovf=0 constantly, and for bin >999 SHALL output the value modulo 1000 (e.g. 1023 -> 0/2/3).

Structure
REQ-024 SHALL use a shared package bin_to_bcd_pkg holding the state enum plus the constants BIN_W=10, DIGITS=3, SHIFTS=10 and MAX_VAL=999.
REQ-025 SHALL place the per-digit add-3 correction in a combinational sub-module bcd_add3_digit, instantiated DIGITS times.

Verification
REQ-026 SHALL cover: bin=345, start pulse at t -> done at t+11 with num2/num1/num0 = 3/4/5, ovf=0, busy high t+1..t+11.
REQ-027 SHALL cover: bin=0 and bin=999 -> 0/0/0 and 9/9/9 respectively, each with done asserted for exactly 1 cycle.
REQ-028 SHALL cover: bin=1023 -> with BIN_TO_BCD_TRIO_SAT_EN, 9/9/9 and ovf=1; without it, 0/2/3 and ovf=0.
REQ-029 SHALL cover: bin=123 started, then start with bin=456 at t+5 -> single done at t+11 showing 1/2/3, and no second done.
REQ-030 SHALL cover: rst pulsed at t+6 during a conversion -> all outputs 0 immediately and no done; a following start with bin=78 -> 0/7/8 after 11 cycles.
REQ-031 SHALL cover: start held high with bin=512 -> done pulses at 12-cycle spacing, each showing 5/1/2.
